// File: rtl/alu_issue.sv
// Three-cycle issue stage: decodes one instruction, presents registered operands
// to an external combinational ALU and writes its result back into a 4x16 register file.
module alu_issue (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  instr,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    output logic        wb_en,
    output logic [1:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        zflag,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_NIBBLE = 3'd2;
    localparam logic [2:0] OP_SPLIT  = 3'd4;
    localparam logic [2:0] OP_MOD2   = 3'd5;
    localparam logic [2:0] OP_PASSB  = 3'd6;
    localparam logic [2:0] OP_LI     = 3'd7;

    state_t      state, state_nxt;
    logic [15:0] regs [4];
    logic [1:0]  rd_q;

    logic [2:0]  opc;
    logic [1:0]  rd, rs;
    logic [2:0]  imm3;
    logic [2:0]  op_nxt;
    logic [15:0] b_nxt;
    logic        accept;

    assign opc  = instr[9:7];
    assign rd   = instr[6:5];
    assign rs   = instr[4:3];
    assign imm3 = instr[2:0];

    assign in_ready = (state == IDLE);
    assign accept   = in_ready && in_valid;
    assign rd_data  = regs[rd_addr];

    // NOTE: the state register uses non-blocking assignment so every flop
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand-B selection; LI is folded into pass-B with the immediate as B.
    always_comb begin
        op_nxt = opc;
        b_nxt  = regs[rs];
        case (opc)
            OP_NIBBLE: b_nxt = {14'b0, imm3[1:0]};
            OP_SPLIT:  b_nxt = {15'b0, imm3[0]};
            OP_MOD2:   b_nxt = 16'h0000;
            OP_LI: begin
                op_nxt = OP_PASSB;
                b_nxt  = {13'b0, imm3};
            end
            default: ;
        endcase
    end

    // NOTE: the register file is reset explicitly because software-visible
    // state must read zero after reset; this keeps it out of plain RAM macros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            rd_q    <= '0;
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            zflag   <= 1'b0;
        end else begin
            wb_en <= (state == EXEC);
            if (accept) begin
                alu_op <= op_nxt;
                alu_a  <= regs[rd];
                alu_b  <= b_nxt;
                rd_q   <= rd;
            end
            // Result is captured at the end of EXEC, before the next operand read.
            if (state == EXEC) begin
                regs[rd_q] <= alu_out;
                wb_addr    <= rd_q;
                wb_data    <= alu_out;
                zflag      <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a behavioural ALU model closes the loop,
// directed vectors check each instruction, and sequences cover throughput and reset abort.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  instr;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_out;
    logic        alu_zero;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [15:0] wb_data;
    logic        zflag;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    alu_issue dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .zflag(zflag), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Downstream ALU: add, sub, nibble parity, and, byte split, mod2, pass B.
    always_comb begin
        logic [15:0] sh;
        sh      = alu_a >> (alu_b[1:0] * 4);
        alu_out = 16'h0000;
        case (alu_op)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = {15'b0, ^sh[3:0]};
            3'd3: alu_out = alu_a & alu_b;
            3'd4: alu_out = alu_b[0] ? {8'h00, alu_a[7:0]} : {8'h00, alu_a[15:8]};
            3'd5: alu_out = {15'b0, alu_a[0]};
            3'd6: alu_out = alu_b;
            default: alu_out = 16'h0000;
        endcase
        alu_zero = (alu_out == 16'h0000);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic read_reg(input logic [1:0] a, input string name, input logic [15:0] exp);
        rd_addr = a;
        #1;
        check(name, rd_data, exp);
    endtask

    // Presents one instruction for a single accepting edge; returns in EXEC at a negedge.
    task automatic issue(input logic [9:0] w);
        int n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", {15'b0, in_ready}, 16'h0001);
        instr    = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  ins;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  addr;
        logic [15:0] data;
        logic        z;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int acc;
        int nwb;
        logic [15:0] wbs [3];
        logic [9:0] w;

        vecs[0]  = '{10'b1110100101, 3'd6, 16'd0,  16'd5,  2'd1, 16'h0005, 1'b0}; // LI R1,5
        vecs[1]  = '{10'b0000101000, 3'd0, 16'd5,  16'd5,  2'd1, 16'h000A, 1'b0}; // ADD R1,R1
        vecs[2]  = '{10'b0010101000, 3'd1, 16'd10, 16'd10, 2'd1, 16'h0000, 1'b1}; // SUB R1,R1
        vecs[3]  = '{10'b1111000111, 3'd6, 16'd0,  16'd7,  2'd2, 16'h0007, 1'b0}; // LI R2,7
        vecs[4]  = '{10'b0101000000, 3'd2, 16'd7,  16'd0,  2'd2, 16'h0001, 1'b0}; // parity R2 nib0
        vecs[5]  = '{10'b1110100101, 3'd6, 16'd0,  16'd5,  2'd1, 16'h0005, 1'b0}; // LI R1,5
        vecs[6]  = '{10'b1000100001, 3'd4, 16'd5,  16'd1,  2'd1, 16'h0005, 1'b0}; // SPLIT R1 low
        vecs[7]  = '{10'b1010100000, 3'd5, 16'd5,  16'd0,  2'd1, 16'h0001, 1'b0}; // MOD2 R1
        vecs[8]  = '{10'b1111100110, 3'd6, 16'd0,  16'd6,  2'd3, 16'h0006, 1'b0}; // LI R3,6
        vecs[9]  = '{10'b0111101000, 3'd3, 16'd6,  16'd1,  2'd3, 16'h0000, 1'b1}; // AND R3,R1
        vecs[10] = '{10'b1001100000, 3'd4, 16'd0,  16'd0,  2'd3, 16'h0000, 1'b1}; // SPLIT R3 high
        vecs[11] = '{10'b0001011000, 3'd0, 16'd1,  16'd0,  2'd2, 16'h0001, 1'b0}; // ADD R2,R3

        reset_n  = 1'b0;
        in_valid = 1'b1;
        instr    = 10'b1110100101;
        rd_addr  = 2'd0;
        repeat (2) @(negedge clk);

        check("rst_in_ready", {15'b0, in_ready}, 16'h0001);
        check("rst_alu_op",   {13'b0, alu_op},   16'h0000);
        check("rst_alu_a",    alu_a,             16'h0000);
        check("rst_alu_b",    alu_b,             16'h0000);
        check("rst_wb_en",    {15'b0, wb_en},    16'h0000);
        check("rst_wb_addr",  {14'b0, wb_addr},  16'h0000);
        check("rst_wb_data",  wb_data,           16'h0000);
        check("rst_zflag",    {15'b0, zflag},    16'h0000);
        for (int r = 0; r < 4; r++) read_reg(2'(r), "rst_reg", 16'h0000);

        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].ins);
            check("exec_ready",  {15'b0, in_ready}, 16'h0000);
            check("exec_wb_en",  {15'b0, wb_en},    16'h0000);
            check("exec_alu_op", {13'b0, alu_op},   {13'b0, vecs[i].op});
            check("exec_alu_a",  alu_a,             vecs[i].a);
            check("exec_alu_b",  alu_b,             vecs[i].b);
            @(negedge clk);
            check("wb_ready",    {15'b0, in_ready}, 16'h0000);
            check("wb_en",       {15'b0, wb_en},    16'h0001);
            check("wb_addr",     {14'b0, wb_addr},  {14'b0, vecs[i].addr});
            check("wb_data",     wb_data,           vecs[i].data);
            check("wb_zflag",    {15'b0, zflag},    {15'b0, vecs[i].z});
            read_reg(vecs[i].addr, "wb_regfile", vecs[i].data);
            @(negedge clk);
            check("idle_ready",  {15'b0, in_ready}, 16'h0001);
            check("idle_wb_en",  {15'b0, wb_en},    16'h0000);
            check("idle_wb_hold", wb_data,          vecs[i].data);
        end

        // Continuous in_valid: only one of every three instructions is taken.
        acc = 0;
        nwb = 0;
        for (int c = 0; c < 9; c++) begin
            w = {3'b111, 2'b00, 2'(c / 8), 3'(c + 1)};
            instr    = w;
            in_valid = 1'b1;
            if (in_ready) acc++;
            if (wb_en && nwb < 3) begin
                wbs[nwb] = wb_data;
                nwb++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("thr_accepts", 16'(acc), 16'd3);
        check("thr_wb_count", 16'(nwb), 16'd3);
        if (nwb == 3) begin
            check("thr_wb0", wbs[0], 16'd1);
            check("thr_wb1", wbs[1], 16'd4);
            check("thr_wb2", wbs[2], 16'd7);
        end
        read_reg(2'd0, "thr_r0", 16'd7);

        // Reset during EXEC aborts the in-flight ADD R3,R1.
        issue(10'b1110100101);
        repeat (2) @(negedge clk);
        issue(10'b0001101000);
        check("abort_exec_a", alu_a, 16'h0000);
        reset_n = 1'b0;
        #1;
        check("abort_ready",   {15'b0, in_ready}, 16'h0001);
        check("abort_alu_op",  {13'b0, alu_op},   16'h0000);
        check("abort_alu_b",   alu_b,             16'h0000);
        check("abort_wb_en",   {15'b0, wb_en},    16'h0000);
        check("abort_wb_data", wb_data,           16'h0000);
        check("abort_wb_addr", {14'b0, wb_addr},  16'h0000);
        @(negedge clk);
        check("abort_wb_en2",  {15'b0, wb_en},    16'h0000);
        read_reg(2'd3, "abort_r3", 16'h0000);
        read_reg(2'd1, "abort_r1", 16'h0000);

        // First edge after release accepts LI R3,3.
        instr    = 10'b1111100011;
        in_valid = 1'b1;
        reset_n  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_ready", {15'b0, in_ready}, 16'h0000);
        check("post_rst_op",    {13'b0, alu_op},   16'h0006);
        check("post_rst_b",     alu_b,             16'h0003);
        @(negedge clk);
        check("post_rst_wb_en", {15'b0, wb_en},    16'h0001);
        check("post_rst_addr",  {14'b0, wb_addr},  16'h0003);
        check("post_rst_data",  wb_data,           16'h0003);
        read_reg(2'd3, "post_rst_r3", 16'h0003);
        @(negedge clk);
        check("post_rst_idle",  {15'b0, in_ready}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
